instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//   Inverse of the instruction decoder. Accepts decoded instruction fields over a valid/ready
//   stream, packs each request into a 32-bit MIPS Instr word, and buffers the words in a
//   DEPTH-entry FIFO drained by a second valid/ready stream. Feeds the boot/test instruction
//   loader and the exception-trampoline writer that fill instruction memory.
// PARAMETERS
//   DEPTH      4    FIFO entries; power of two, >= 2
//   CNT_W      32   width of the issued-word counter
// PORTS
//   clk         in   1       clock; all state updates on rising edge
//   reset       in   1       synchronous reset, active-low
//   flush       in   1       synchronous FIFO clear; has priority over push and pop
//   in_valid    in   1       request valid
//   in_ready    out  1       request accepted when in_valid & in_ready
//   opCode      in   6       OpCodeEnum; selects the packing format
//   funct       in   6       SpecCode / Spec2Code / Cop0 co-function
//   subCode     in   5       RegimmCode (REGIMM) or COP0 rs sub-op (MFC0/MTC0)
//   cop0Co      in   1       COP0 only: 1 sets instr[25] and funct is used
//   rs, rt, rd  in   5 each  register addresses
//   shamt       in   5       shift amount
//   immediate   in   26      imm16 in [15:0] (I-type), or target26 (J/JAL)
//   out_valid   out  1       FIFO non-empty
//   out_ready   in   1       consumer accepts head word
//   out_instr   out  32      head word
//   out_err     out  1       head word flagged malformed (0 unless ENCODER_CHECK_EN)
//   issued      out  CNT_W   count of out handshakes; wraps modulo 2^CNT_W
// BEHAVIOUR
//   Reset (reset==0 at an edge): FIFO empty, out_valid=0, in_ready=1, out_instr=0,
//     out_err=0, issued=0. Reset mid-stream discards all buffered words.
//   Packing (combinational, at accept):
//     SPECIAL/SPECIAL2: {op, rs, rt, rd, shamt, funct}
//     J/JAL:            {op, immediate[25:0]}
//     REGIMM:           {op, rs, subCode, immediate[15:0]}
//     COP0, cop0Co=1:   {op, 1'b1, 19'b0, funct}
//     COP0, cop0Co=0:   {op, subCode, rt, rd, 11'b0}
//     other op:         {op, rs, rt, immediate[15:0]}
//   Latency: word accepted at edge N is visible at out_instr with out_valid=1 after edge N,
//     provided the FIFO was empty. Order is strictly FIFO.
//   in_ready = (occupancy < DEPTH), derived from registered occupancy only; no combinational
//     path from out_ready to in_ready. When full, push is refused even if a pop occurs in
//     the same cycle.
//   Push and pop in the same cycle with 0 < occupancy < DEPTH: occupancy unchanged.
//   Pop on empty is ignored. out_instr holds its value while out_valid & ~out_ready.
//   Pointers are log2(DEPTH) bits and wrap naturally; occupancy is log2(DEPTH)+1 bits.
//   flush: occupancy becomes 0 at the next edge; issued is NOT cleared; a push or pop in the
//     flush cycle is discarded and not counted.
//   issued increments by 1 on each out_valid & out_ready; all-ones wraps to 0.
// CONFIGURATION
//   ENCODER_CHECK_EN defined: out_err is stored per entry and set when any of:
//     shamt != 0 for a SPECIAL funct other than SLL/SRL/SRA; immediate[25:16] != 0 for an
//     I-type or REGIMM op; opCode is not a member of OpCodeEnum. The word is still packed
//     and emitted.
//   Not defined: no error storage; out_err tied to 0; out-of-range fields truncated silently.
// STRUCTURE
//   Shared package (Parameter): EncReq struct (opCode, funct, subCode, cop0Co, rs, rt, rd,
//     shamt, immediate) and COP0_CO_BIT = 25. Reuse the existing OpCode/SpecCode/RegimmCode/
//     Cop0Code enums.
//   Sub-module: instr_pack, purely combinational: EncReq -> Instr (+ err when checked).
//   This module holds only the FIFO, handshakes and counter.
// TESTING
//   ADDIU rs=0 rt=8 imm=5 into empty FIFO -> next cycle out_valid=1, out_instr=0x24080005.
//   SLL rd=1 rt=2 shamt=3 funct=0, then J immediate=0x0100000 -> 0x000208C0 then 0x08100000, in order.
//   REGIMM rs=3 subCode=1 (BGEZ) imm=0xFFFF; then COP0 cop0Co=0 subCode=4 rt=8 rd=12 (MTC0)
//     -> 0x0461FFFF, 0x40886000; COP0 cop0Co=1 funct=0x18 (ERET) -> 0x42000018.
//   Hold out_ready=0 and push DEPTH words -> in_ready=0; assert pop with push ->
//     push refused, next cycle in_ready=1; issued advances by exactly 1.
//   Fill 3 words, assert flush with push and pop -> out_valid=0 next cycle, issued
//     unchanged; assert reset=0 mid-stream -> all outputs at reset values.
//   ENCODER_CHECK_EN: ADDU with shamt=2 -> out_err=1 with word emitted; without the
//     macro -> out_err=0.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared types for the instruction encoder: opcode/function enums, the encode request
// struct and small field-classification helpers.
package instr_encoder_pkg;

  localparam int COP0_CO_BIT = 25;

  typedef enum logic [5:0] {
    OP_SPECIAL  = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03,
    OP_BEQ      = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07,
    OP_ADDI     = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B,
    OP_ANDI     = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F,
    OP_COP0     = 6'h10, OP_SPECIAL2 = 6'h1C,
    OP_LB       = 6'h20, OP_LH     = 6'h21, OP_LWL   = 6'h22, OP_LW    = 6'h23,
    OP_LBU      = 6'h24, OP_LHU    = 6'h25, OP_LWR   = 6'h26,
    OP_SB       = 6'h28, OP_SH     = 6'h29, OP_SWL   = 6'h2A, OP_SW    = 6'h2B,
    OP_SWR      = 6'h2E, OP_CACHE  = 6'h2F, OP_LL    = 6'h30, OP_PREF  = 6'h33,
    OP_SC       = 6'h38
  } op_code_e;

  typedef enum logic [5:0] {
    SP_SLL  = 6'h00, SP_SRL  = 6'h02, SP_SRA  = 6'h03, SP_SLLV = 6'h04,
    SP_JR   = 6'h08, SP_JALR = 6'h09, SP_ADDU = 6'h21, SP_SUBU = 6'h23,
    SP_AND  = 6'h24, SP_OR   = 6'h25, SP_SLT  = 6'h2A
  } spec_code_e;

  typedef enum logic [4:0] {
    RI_BLTZ = 5'h00, RI_BGEZ = 5'h01, RI_BLTZAL = 5'h10, RI_BGEZAL = 5'h11
  } regimm_code_e;

  typedef enum logic [5:0] {
    C0_TLBR = 6'h01, C0_TLBWI = 6'h02, C0_ERET = 6'h18, C0_WAIT = 6'h20
  } cop0_code_e;

  typedef struct packed {
    logic [5:0]  op_code;
    logic [5:0]  funct;
    logic [4:0]  sub_code;
    logic        cop0_co;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [25:0] immediate;
  } enc_req_t;

  function automatic logic is_opcode(input logic [5:0] op);
    case (op)
      OP_SPECIAL, OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
      OP_COP0, OP_SPECIAL2, OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR, OP_CACHE, OP_LL, OP_PREF, OP_SC:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

  function automatic logic is_shift_funct(input logic [5:0] fn);
    case (fn)
      SP_SLL, SP_SRL, SP_SRA: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: one encode request -> one 32-bit instruction word.
// With ENCODER_CHECK_EN defined it also flags malformed requests on err.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  enc_req_t    req,
`ifdef ENCODER_CHECK_EN
  output logic        err,
`endif
  output logic [31:0] instr
);

  // Select the bit layout from the opcode.
  always_comb begin
    instr = 32'h0000_0000;
    case (req.op_code)
      OP_SPECIAL, OP_SPECIAL2:
        instr = {req.op_code, req.rs, req.rt, req.rd, req.shamt, req.funct};
      OP_J, OP_JAL:
        instr = {req.op_code, req.immediate};
      OP_REGIMM:
        instr = {req.op_code, req.rs, req.sub_code, req.immediate[15:0]};
      OP_COP0: begin
        if (req.cop0_co) begin
          instr = {req.op_code, 20'h0_0000, req.funct};
          instr[COP0_CO_BIT] = 1'b1;
        end else begin
          instr = {req.op_code, req.sub_code, req.rt, req.rd, 11'h000};
        end
      end
      default:
        instr = {req.op_code, req.rs, req.rt, req.immediate[15:0]};
    endcase
  end

`ifdef ENCODER_CHECK_EN
  // Unknown opcodes fall through to the I-type layout, so they get the imm check too.
  always_comb begin
    err = ~is_opcode(req.op_code);
    case (req.op_code)
      OP_SPECIAL: begin
        if ((req.shamt != 5'd0) && !is_shift_funct(req.funct)) begin
          err = 1'b1;
        end else begin
          err = err;
        end
      end
      OP_SPECIAL2, OP_J, OP_JAL, OP_COP0: begin
        err = err;
      end
      default: begin
        if (req.immediate[25:16] != 10'h000) begin
          err = 1'b1;
        end else begin
          err = err;
        end
      end
    endcase
  end
`endif

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs decoded fields into MIPS words and buffers them in a
// DEPTH-entry FIFO. Define ENCODER_CHECK_EN to store a per-entry malformed flag on out_err.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opCode,
  input  logic [5:0]       funct,
  input  logic [4:0]       subCode,
  input  logic             cop0Co,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,
  input  logic [4:0]       shamt,
  input  logic [25:0]      immediate,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] issued
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(DEPTH);

  enc_req_t          req_s;
  logic [31:0]       word_s;
  logic              push_s;
  logic              pop_s;
  logic [31:0]       mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    count_r;
  logic [CNT_W-1:0]  issued_r;

  assign req_s = '{op_code: opCode, funct: funct, sub_code: subCode, cop0_co: cop0Co,
                   rs: rs, rt: rt, rd: rd, shamt: shamt, immediate: immediate};

  // in_ready and out_valid depend on registered occupancy only, never on out_ready.
  assign in_ready  = (count_r != DEPTH_C);
  assign out_valid = (count_r != {(PTR_W + 1){1'b0}});
  assign push_s    = in_valid & in_ready & ~flush;
  assign pop_s     = out_valid & out_ready & ~flush;
  assign out_instr = mem_r[rd_ptr_r];
  assign issued    = issued_r;

`ifdef ENCODER_CHECK_EN
  logic       err_s;
  logic [DEPTH-1:0] err_r;

  instr_pack u_pack (.req(req_s), .err(err_s), .instr(word_s));

  // Per-entry malformed flag, written alongside the word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_r <= '0;
    end else if (push_s) begin
      err_r[wr_ptr_r] <= err_s;
    end
  end

  assign out_err = err_r[rd_ptr_r];
`else
  instr_pack u_pack (.req(req_s), .instr(word_s));

  assign out_err = 1'b0;
`endif

  // FIFO storage, pointers and occupancy; flush empties without touching storage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= word_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
        2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Issued-word counter; survives flush and wraps naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      issued_r <= '0;
    end else if (pop_s) begin
      issued_r <= issued_r + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words queued on accept, compared on pop.
module tb_instr_encoder;

  localparam int DEPTH = 4;
`ifdef ENCODER_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, cop0Co, out_valid, out_ready, out_err;
  logic [5:0]  opCode, funct;
  logic [4:0]  subCode, rs, rt, rd, shamt;
  logic [25:0] immediate;
  logic [31:0] out_instr, issued;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          pop_cnt = 0;
  logic [32:0] sb[$];
  logic [32:0] exp_next;
  logic [32:0] head_v;
  logic [31:0] base_v;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opCode(opCode), .funct(funct), .subCode(subCode), .cop0Co(cop0Co),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .immediate(immediate),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .issued(issued)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampling mid-cycle away from the rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      pop_cnt = 0;
    end else if (flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_val("unexpected_pop", 32'd1, 32'd0);
        end else begin
          head_v = sb.pop_front();
          check_val("out_instr", out_instr, head_v[31:0]);
          check_val("out_err", {31'd0, out_err}, {31'd0, head_v[32]});
          pop_cnt++;
        end
      end
      if (in_valid && in_ready) sb.push_back(exp_next);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sc,
                      input logic co, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [4:0] sh, input logic [25:0] im,
                      input logic [31:0] ew, input logic ee, input bit rnd);
    int budget = 0;
    bit acc = 1'b0;
    opCode = op; funct = fn; subCode = sc; cop0Co = co;
    rs = s; rt = t; rd = d; shamt = sh; immediate = im;
    exp_next = {ee, ew};
    in_valid = 1'b1;
    while (!acc && budget < 200) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    in_valid = 1'b0;
    if (!acc) check_val("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int budget = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && budget < 100) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check_val("drain_left", 32'(sb.size()), 32'd0);
    @(negedge clk);
    check_val("drain_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("issued_count", issued, 32'(pop_cnt));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string pfx);
    check_val({pfx, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check_val({pfx, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check_val({pfx, "_out_instr"}, out_instr, 32'h0000_0000);
    check_val({pfx, "_out_err"}, {31'd0, out_err}, 32'd0);
    check_val({pfx, "_issued"}, issued, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  r_s, r_t;
    logic [15:0] r_im;
    logic [5:0]  r_op;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opCode = 6'd0; funct = 6'd0; subCode = 5'd0; cop0Co = 1'b0;
    rs = 5'd0; rt = 5'd0; rd = 5'd0; shamt = 5'd0; immediate = 26'd0;
    exp_next = 33'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // First-word latency into an empty FIFO.
    send(6'h09, 6'h00, 5'd0, 1'b0, 5'd0, 5'd8, 5'd0, 5'd0, 26'h0000005, 32'h2408_0005, 1'b0, 1'b0);
    @(negedge clk);
    check_val("lat_out_valid", {31'd0, out_valid}, 32'd1);
    check_val("lat_out_instr", out_instr, 32'h2408_0005);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Directed formats.
    send(6'h00, 6'h00, 5'd0, 1'b0, 5'd0, 5'd2, 5'd1, 5'd3, 26'd0, 32'h0002_08C0, 1'b0, 1'b0);
    send(6'h02, 6'h00, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 26'h0100000, 32'h0810_0000, 1'b0, 1'b0);
    send(6'h01, 6'h00, 5'd1, 1'b0, 5'd3, 5'd0, 5'd0, 5'd0, 26'h000FFFF, 32'h0461_FFFF, 1'b0, 1'b0);
    send(6'h10, 6'h00, 5'd4, 1'b0, 5'd0, 5'd8, 5'd12, 5'd0, 26'd0, 32'h4088_6000, 1'b0, 1'b0);
    send(6'h10, 6'h18, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 32'h4200_0018, 1'b0, 1'b0);
    send(6'h00, 6'h21, 5'd0, 1'b0, 5'd1, 5'd2, 5'd3, 5'd2, 26'd0, 32'h0022_18A1, CHK, 1'b0);
    drain();

    // Random I-type words with a random consumer.
    for (int i = 0; i < 8; i++) begin
      r_s  = 5'($urandom_range(0, 31));
      r_t  = 5'($urandom_range(0, 31));
      r_im = 16'($urandom_range(0, 65535));
      r_op = (i % 2 == 0) ? 6'h09 : 6'h0D;
      send(r_op, 6'h00, 5'd0, 1'b0, r_s, r_t, 5'd0, 5'd0, {10'd0, r_im},
           {r_op, r_s, r_t, r_im}, 1'b0, 1'b1);
    end
    drain();

    // Full FIFO: push refused even with a simultaneous pop.
    for (int i = 0; i < DEPTH; i++) begin
      send(6'h09, 6'h00, 5'd0, 1'b0, 5'd1, 5'd2, 5'd0, 5'd0, 26'(i + 16), 32'h2422_0010 + 32'(i), 1'b0, 1'b0);
    end
    @(negedge clk);
    check_val("full_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    base_v = issued;
    exp_next = {1'b0, 32'hDEAD_BEEF};
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check_val("full_pop_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("full_pop_issued", issued, base_v + 32'd1);
    check_val("full_pop_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Flush with simultaneous push and pop.
    for (int i = 0; i < 3; i++) begin
      send(6'h0D, 6'h00, 5'd0, 1'b0, 5'd4, 5'd5, 5'd0, 5'd0, 26'(i), 32'h3485_0000 + 32'(i), 1'b0, 1'b0);
    end
    base_v = issued;
    flush = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check_val("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("flush_issued", issued, base_v);
    check_val("flush_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Reset mid-stream, then confirm normal operation resumes.
    send(6'h09, 6'h00, 5'd0, 1'b0, 5'd0, 5'd8, 5'd0, 5'd0, 26'h0000005, 32'h2408_0005, 1'b0, 1'b0);
    send(6'h02, 6'h00, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 26'h0100000, 32'h0810_0000, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_state("midreset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    send(6'h10, 6'h18, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 32'h4200_0018, 1'b0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
